// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage controller: owns the PC, fetches from instruction memory and sequences the branch-target adder.
// Optional build macro MISALIGN_TRAP_EN adds the FAULT state and the o_Misalign flag.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADD_LAT  = 1
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Enb,
  output logic        o_Imem_req,
  output logic [31:0] ov_Imem_addr,
  input  logic        i_Imem_ack,
  input  logic [31:0] iv_Imem_data,
  output logic        o_Instr_valid,
  output logic [31:0] ov_Instr,
  output logic [31:0] ov_Instr_pc,
  input  logic        i_Instr_ready,
  input  logic        i_Redirect,
  input  logic [31:0] iv_Redirect_base,
  input  logic [31:0] iv_Redirect_imm,
  output logic [31:0] ov_Add_dir,
  output logic [31:0] ov_Add_imm,
  output logic        o_Add_enb,
  input  logic [31:0] iv_Add_result
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        o_Misalign
`endif
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_WAIT_ACK = 3'd1,
    S_HOLD     = 3'd2,
    S_CALC     = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  localparam logic [2:0] LP_LAT = 3'(ADD_LAT);

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_imem_req;
  logic        r_instr_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [31:0] r_add_dir;
  logic [31:0] r_add_imm;
  logic        r_add_enb;
  logic [2:0]  r_cnt;
  logic        r_redir_pend;
  logic        r_redir_new;
  logic [31:0] r_base;
  logic [31:0] r_imm;
  logic        r_ack_held;
  logic [31:0] r_ack_data;
`ifdef MISALIGN_TRAP_EN
  logic        r_misalign;
`endif

  logic        w_new_redir;
  logic        w_any_redir;
  logic [31:0] w_base;
  logic [31:0] w_imm;
  logic        w_ack;
  logic [31:0] w_data;
  logic [31:0] w_target;
  logic        w_enter_calc;

  // A redirect or ack seen while frozen is remembered so it is acted on once i_Enb returns.
  assign w_new_redir = i_Redirect | r_redir_new;
  assign w_any_redir = w_new_redir | r_redir_pend;
  assign w_base      = i_Redirect ? iv_Redirect_base : r_base;
  assign w_imm       = i_Redirect ? iv_Redirect_imm  : r_imm;
  assign w_ack       = i_Imem_ack | r_ack_held;
  assign w_data      = r_ack_held ? r_ack_data : iv_Imem_data;
`ifdef MISALIGN_TRAP_EN
  assign w_target    = iv_Add_result;
`else
  assign w_target    = iv_Add_result & 32'hFFFF_FFFC;
`endif

  always_comb begin
    w_enter_calc = 1'b0;
    if (i_Enb) begin
      case (r_state)
        S_FETCH:    w_enter_calc = w_any_redir;
        S_WAIT_ACK: w_enter_calc = w_ack & w_any_redir;
        S_HOLD:     w_enter_calc = w_any_redir;
        S_CALC:     w_enter_calc = w_new_redir;
        S_FAULT:    w_enter_calc = w_new_redir;
        default:    w_enter_calc = 1'b0;
      endcase
    end else begin
      w_enter_calc = 1'b0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= 32'h0000_0000;
      r_instr_pc    <= 32'h0000_0000;
      r_add_dir     <= 32'h0000_0000;
      r_add_imm     <= 32'h0000_0000;
      r_add_enb     <= 1'b0;
      r_cnt         <= 3'd0;
      r_redir_pend  <= 1'b0;
      r_redir_new   <= 1'b0;
      r_base        <= 32'h0000_0000;
      r_imm         <= 32'h0000_0000;
      r_ack_held    <= 1'b0;
      r_ack_data    <= 32'h0000_0000;
`ifdef MISALIGN_TRAP_EN
      r_misalign    <= 1'b0;
`endif
    end else begin
      if (i_Redirect) begin
        r_base       <= iv_Redirect_base;
        r_imm        <= iv_Redirect_imm;
        r_redir_pend <= 1'b1;
      end
      if (!i_Enb) begin
        if (i_Redirect) r_redir_new <= 1'b1;
        if ((r_state == S_WAIT_ACK) && i_Imem_ack) begin
          r_ack_held <= 1'b1;
          r_ack_data <= iv_Imem_data;
        end
      end else begin
        r_redir_new <= 1'b0;
        r_ack_held  <= 1'b0;
        case (r_state)
          S_FETCH: begin
            if (!w_enter_calc) begin
              r_imem_req <= 1'b1;
              r_state    <= S_WAIT_ACK;
            end
          end
          S_WAIT_ACK: begin
            if (w_ack) begin
              r_imem_req <= 1'b0;
              if (!w_enter_calc) begin
                r_instr       <= w_data;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
                r_pc          <= r_pc + 32'd4;
                r_state       <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (w_enter_calc || i_Instr_ready) begin
              r_instr_valid <= 1'b0;
              r_state       <= S_FETCH;
            end
          end
          S_CALC: begin
            if (!w_enter_calc) begin
              if (r_cnt == LP_LAT) begin
                r_add_enb    <= 1'b0;
                r_redir_pend <= 1'b0;
                r_pc         <= w_target;
`ifdef MISALIGN_TRAP_EN
                if (|iv_Add_result[1:0]) begin
                  r_misalign <= 1'b1;
                  r_state    <= S_FAULT;
                end else begin
                  r_state    <= S_FETCH;
                end
`else
                r_state      <= S_FETCH;
`endif
              end else begin
                r_cnt <= r_cnt + 3'd1;
              end
            end
          end
`ifdef MISALIGN_TRAP_EN
          S_FAULT: begin
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
          end
`endif
          default: r_state <= S_FETCH;
        endcase
        // Shared entry into CALC: takes priority over the per-state next-state above.
        if (w_enter_calc) begin
          r_add_dir <= w_base;
          r_add_imm <= w_imm;
          r_add_enb <= 1'b1;
          r_cnt     <= 3'd0;
          r_state   <= S_CALC;
        end
      end
    end
  end

  assign o_Imem_req    = r_imem_req;
  assign ov_Imem_addr  = r_pc;
  assign o_Instr_valid = r_instr_valid;
  assign ov_Instr      = r_instr;
  assign ov_Instr_pc   = r_instr_pc;
  assign ov_Add_dir    = r_add_dir;
  assign ov_Add_imm    = r_add_imm;
  assign o_Add_enb     = r_add_enb;
`ifdef MISALIGN_TRAP_EN
  assign o_Misalign    = r_misalign;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: per-cycle vector table plus hand sequences for redirect/reset corners.
module tb_pc_fetch_sequencer;
  localparam int LAT = 2;

  logic        i_Clk = 1'b0;
  logic        i_Rst, i_Enb, i_Imem_ack, i_Instr_ready, i_Redirect;
  logic [31:0] iv_Imem_data, iv_Redirect_base, iv_Redirect_imm, iv_Add_result;
  logic        o_Imem_req, o_Instr_valid, o_Add_enb;
  logic [31:0] ov_Imem_addr, ov_Instr, ov_Instr_pc, ov_Add_dir, ov_Add_imm;
`ifdef MISALIGN_TRAP_EN
  logic        o_Misalign;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 i_Clk = ~i_Clk;

  pc_fetch_sequencer #(.RESET_PC(32'h0000_0100), .ADD_LAT(LAT)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Enb(i_Enb),
    .o_Imem_req(o_Imem_req), .ov_Imem_addr(ov_Imem_addr),
    .i_Imem_ack(i_Imem_ack), .iv_Imem_data(iv_Imem_data),
    .o_Instr_valid(o_Instr_valid), .ov_Instr(ov_Instr), .ov_Instr_pc(ov_Instr_pc),
    .i_Instr_ready(i_Instr_ready),
    .i_Redirect(i_Redirect), .iv_Redirect_base(iv_Redirect_base), .iv_Redirect_imm(iv_Redirect_imm),
    .ov_Add_dir(ov_Add_dir), .ov_Add_imm(ov_Add_imm), .o_Add_enb(o_Add_enb),
    .iv_Add_result(iv_Add_result)
`ifdef MISALIGN_TRAP_EN
    , .o_Misalign(o_Misalign)
`endif
  );

  // Model of the registered ADD_imm block with LAT pipeline stages.
  logic [31:0] add_pipe [LAT];
  always @(posedge i_Clk) begin
    if (o_Add_enb) begin
      add_pipe[0] <= ov_Add_dir + ov_Add_imm;
      for (int k = 1; k < LAT; k++) add_pipe[k] <= add_pipe[k-1];
    end
  end
  assign iv_Add_result = add_pipe[LAT-1];

  typedef struct {
    logic        rst_n, enb, ack;
    logic [31:0] data;
    logic        ready, redir;
    logic [31:0] base, imm;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ipc, instr;
    logic        aenb;
    logic [31:0] adir, aimm;
  } vec_t;

  vec_t vecs[$];

  task automatic av(input logic rst_n, enb, ack, input logic [31:0] data, input logic ready, redir,
                    input logic [31:0] base, imm, input logic req, input logic [31:0] addr,
                    input logic valid, input logic [31:0] ipc, instr, input logic aenb,
                    input logic [31:0] adir, aimm);
    vec_t v;
    v.rst_n = rst_n; v.enb = enb; v.ack = ack; v.data = data; v.ready = ready; v.redir = redir;
    v.base = base; v.imm = imm; v.req = req; v.addr = addr; v.valid = valid; v.ipc = ipc;
    v.instr = instr; v.aenb = aenb; v.adir = adir; v.aimm = aimm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".req"},   {31'd0, o_Imem_req},    32'd0);
    chk({tag, ".valid"}, {31'd0, o_Instr_valid}, 32'd0);
    chk({tag, ".addr"},  ov_Imem_addr,           32'h0000_0100);
    chk({tag, ".instr"}, ov_Instr,               32'h0000_0000);
    chk({tag, ".ipc"},   ov_Instr_pc,            32'h0000_0000);
    chk({tag, ".aenb"},  {31'd0, o_Add_enb},     32'd0);
    chk({tag, ".adir"},  ov_Add_dir,             32'h0000_0000);
    chk({tag, ".aimm"},  ov_Add_imm,             32'h0000_0000);
  endtask

  initial begin
    i_Rst = 1'b0; i_Enb = 1'b1; i_Imem_ack = 1'b0; iv_Imem_data = 32'h0;
    i_Instr_ready = 1'b1; i_Redirect = 1'b0; iv_Redirect_base = 32'h0; iv_Redirect_imm = 32'h0;

    // Sequential fetch 0x100,0x104,0x108 with single-cycle ack and ready=1.
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               0,32'h100,0,32'h0,32'h0,0,32'h0,32'h0);
    av(1,1,1,32'hA000_0000,1,0,32'h0,32'h0,       1,32'h100,0,32'h0,32'h0,0,32'h0,32'h0);
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               0,32'h104,1,32'h100,32'hA000_0000,0,32'h0,32'h0);
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               0,32'h104,0,32'h100,32'hA000_0000,0,32'h0,32'h0);
    av(1,1,1,32'hA000_0001,1,0,32'h0,32'h0,       1,32'h104,0,32'h100,32'hA000_0000,0,32'h0,32'h0);
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               0,32'h108,1,32'h104,32'hA000_0001,0,32'h0,32'h0);
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               0,32'h108,0,32'h104,32'hA000_0001,0,32'h0,32'h0);
    av(1,1,1,32'hA000_0002,1,0,32'h0,32'h0,       1,32'h108,0,32'h104,32'hA000_0001,0,32'h0,32'h0);
    // Decode stalls five cycles: output held, no new request.
    for (int k = 0; k < 5; k++)
      av(1,1,0,32'h0,0,0,32'h0,32'h0,             0,32'h10C,1,32'h108,32'hA000_0002,0,32'h0,32'h0);
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               0,32'h10C,1,32'h108,32'hA000_0002,0,32'h0,32'h0);
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               0,32'h10C,0,32'h108,32'hA000_0002,0,32'h0,32'h0);
    // Redirect 0x200+0x40 during WAIT_ACK, ack three cycles later, data dropped.
    av(1,1,0,32'h0,1,1,32'h200,32'h40,            1,32'h10C,0,32'h108,32'hA000_0002,0,32'h0,32'h0);
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               1,32'h10C,0,32'h108,32'hA000_0002,0,32'h0,32'h0);
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               1,32'h10C,0,32'h108,32'hA000_0002,0,32'h0,32'h0);
    av(1,1,1,32'hA000_0003,1,0,32'h0,32'h0,       1,32'h10C,0,32'h108,32'hA000_0002,0,32'h0,32'h0);
    for (int k = 0; k < 3; k++)
      av(1,1,0,32'h0,1,0,32'h0,32'h0,             0,32'h10C,0,32'h108,32'hA000_0002,1,32'h200,32'h40);
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               0,32'h240,0,32'h108,32'hA000_0002,0,32'h200,32'h40);
    av(1,1,1,32'hA000_0004,1,0,32'h0,32'h0,       1,32'h240,0,32'h108,32'hA000_0002,0,32'h200,32'h40);
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               0,32'h244,1,32'h240,32'hA000_0004,0,32'h200,32'h40);
    // Back-to-back redirects: the second restarts CALC, target 0x320.
    av(1,1,0,32'h0,1,1,32'h300,32'h10,            0,32'h244,0,32'h240,32'hA000_0004,0,32'h200,32'h40);
    av(1,1,0,32'h0,1,1,32'h300,32'h20,            0,32'h244,0,32'h240,32'hA000_0004,1,32'h300,32'h10);
    for (int k = 0; k < 3; k++)
      av(1,1,0,32'h0,1,0,32'h0,32'h0,             0,32'h244,0,32'h240,32'hA000_0004,1,32'h300,32'h20);
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               0,32'h320,0,32'h240,32'hA000_0004,0,32'h300,32'h20);
    av(1,1,1,32'hA000_0005,1,0,32'h0,32'h0,       1,32'h320,0,32'h240,32'hA000_0004,0,32'h300,32'h20);
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               0,32'h324,1,32'h320,32'hA000_0005,0,32'h300,32'h20);
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               0,32'h324,0,32'h320,32'hA000_0005,0,32'h300,32'h20);
    av(1,1,1,32'hA000_0006,1,0,32'h0,32'h0,       1,32'h324,0,32'h320,32'hA000_0005,0,32'h300,32'h20);
    // Redirect in HOLD to 0xFFFF_FFFC, then PC wraps to 0.
    av(1,1,0,32'h0,0,1,32'hFFFF_FFF0,32'hC,       0,32'h328,1,32'h324,32'hA000_0006,0,32'h300,32'h20);
    for (int k = 0; k < 3; k++)
      av(1,1,0,32'h0,1,0,32'h0,32'h0,             0,32'h328,0,32'h324,32'hA000_0006,1,32'hFFFF_FFF0,32'hC);
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               0,32'hFFFF_FFFC,0,32'h324,32'hA000_0006,0,32'hFFFF_FFF0,32'hC);
    av(1,1,1,32'hA000_0007,1,0,32'h0,32'h0,       1,32'hFFFF_FFFC,0,32'h324,32'hA000_0006,0,32'hFFFF_FFF0,32'hC);
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               0,32'h0,1,32'hFFFF_FFFC,32'hA000_0007,0,32'hFFFF_FFF0,32'hC);
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               0,32'h0,0,32'hFFFF_FFFC,32'hA000_0007,0,32'hFFFF_FFF0,32'hC);
    // Redirect and ack in the same cycle: data dropped.
    av(1,1,1,32'hA000_0008,1,1,32'h500,32'h8,     1,32'h0,0,32'hFFFF_FFFC,32'hA000_0007,0,32'hFFFF_FFF0,32'hC);
    for (int k = 0; k < 3; k++)
      av(1,1,0,32'h0,1,0,32'h0,32'h0,             0,32'h0,0,32'hFFFF_FFFC,32'hA000_0007,1,32'h500,32'h8);
    // One frozen cycle in FETCH delays the request by one cycle.
    av(1,0,0,32'h0,1,0,32'h0,32'h0,               0,32'h508,0,32'hFFFF_FFFC,32'hA000_0007,0,32'h500,32'h8);
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               0,32'h508,0,32'hFFFF_FFFC,32'hA000_0007,0,32'h500,32'h8);
    av(1,1,1,32'hA000_0009,1,0,32'h0,32'h0,       1,32'h508,0,32'hFFFF_FFFC,32'hA000_0007,0,32'h500,32'h8);
    av(1,1,0,32'h0,1,0,32'h0,32'h0,               0,32'h50C,1,32'h508,32'hA000_0009,0,32'h500,32'h8);
    av(1,1,0,32'h0,1,1,32'h400,32'h2,             0,32'h50C,0,32'h508,32'hA000_0009,0,32'h500,32'h8);

    repeat (3) @(negedge i_Clk);

    foreach (vecs[i]) begin
      i_Rst = vecs[i].rst_n; i_Enb = vecs[i].enb; i_Imem_ack = vecs[i].ack;
      iv_Imem_data = vecs[i].data; i_Instr_ready = vecs[i].ready; i_Redirect = vecs[i].redir;
      iv_Redirect_base = vecs[i].base; iv_Redirect_imm = vecs[i].imm;
      chk($sformatf("v%0d.req", i),   {31'd0, o_Imem_req},    {31'd0, vecs[i].req});
      chk($sformatf("v%0d.addr", i),  ov_Imem_addr,           vecs[i].addr);
      chk($sformatf("v%0d.valid", i), {31'd0, o_Instr_valid}, {31'd0, vecs[i].valid});
      chk($sformatf("v%0d.ipc", i),   ov_Instr_pc,            vecs[i].ipc);
      chk($sformatf("v%0d.instr", i), ov_Instr,               vecs[i].instr);
      chk($sformatf("v%0d.aenb", i),  {31'd0, o_Add_enb},     {31'd0, vecs[i].aenb});
      chk($sformatf("v%0d.adir", i),  ov_Add_dir,             vecs[i].adir);
      chk($sformatf("v%0d.aimm", i),  ov_Add_imm,             vecs[i].aimm);
      @(negedge i_Clk);
    end

    // Misaligned target 0x400+0x2 (redirect issued by the last vector).
    i_Redirect = 1'b0; i_Imem_ack = 1'b0; i_Instr_ready = 1'b1; i_Enb = 1'b1;
    for (int k = 0; k < 20 && o_Add_enb; k++) @(negedge i_Clk);
    chk("calc_done", {31'd0, o_Add_enb}, 32'd0);
`ifdef MISALIGN_TRAP_EN
    chk("mis.flag",  {31'd0, o_Misalign},    32'd1);
    chk("mis.addr",  ov_Imem_addr,           32'h0000_0402);
    repeat (3) @(negedge i_Clk);
    chk("mis.noreq", {31'd0, o_Imem_req},    32'd0);
    chk("mis.valid", {31'd0, o_Instr_valid}, 32'd0);
    chk("mis.hold",  {31'd0, o_Misalign},    32'd1);
    i_Rst = 1'b0;
    @(negedge i_Clk);
    i_Rst = 1'b1;
    chk("mis.clear", {31'd0, o_Misalign},    32'd0);
    chk_reset_state("mis_rst");
`else
    chk("align.addr", ov_Imem_addr, 32'h0000_0400);
    for (int k = 0; k < 10 && !o_Imem_req; k++) @(negedge i_Clk);
    chk("align.req",  {31'd0, o_Imem_req}, 32'd1);
    chk("align.fetch", ov_Imem_addr, 32'h0000_0400);
    // Reset in the middle of a pending fetch aborts it.
    i_Rst = 1'b0;
    @(negedge i_Clk);
    i_Rst = 1'b1;
    chk_reset_state("mid_rst");
`endif
    @(negedge i_Clk);
    chk("post_rst.req",  {31'd0, o_Imem_req}, 32'd1);
    chk("post_rst.addr", ov_Imem_addr,        32'h0000_0100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
